// File: rtl/clk_ratio_monitor.sv
// Receive-side checker for a divided clock: measures half-periods in original_clock cycles and tracks lock.
// Define CLK_MON_MINMAX_EN to enable min/max interval tracking.
module clk_ratio_monitor #(
   parameter int unsigned RATIO      = 5,
   parameter int unsigned TOL        = 0,
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned TIMEOUT    = 20,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             original_clock,
   input  logic             reset_in,
   input  logic             slow_clock_in,
   input  logic             clear_in,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic             locked,
   output logic             fault_sticky,
   output logic [CNT_W-1:0] last_half_period,
   output logic [7:0]       error_count,
   output logic [CNT_W-1:0] min_interval,
   output logic [CNT_W-1:0] max_interval
);
   localparam int unsigned      RUN_W     = 4;
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] RATIO_V   = CNT_W'(RATIO);
   localparam logic [CNT_W-1:0] TOL_V     = CNT_W'(TOL);
   localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
   localparam logic [RUN_W-1:0] LOCK_V    = RUN_W'(LOCK_COUNT);
   localparam logic [7:0]       ERR_MAX   = 8'hFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t           state, state_n;
   logic             s1, s2, s3;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [RUN_W-1:0] good_run, good_run_n;
   logic             locked_n, fault_n;
   logic [7:0]       err_n;
   logic [CNT_W-1:0] last_n;
   logic             edge_c, rise_c, fall_c, good_c, timeout_c, measure_c;
   logic [CNT_W-1:0] interval_c, dev_c;

   // Edge detection and interval measurement on the synchronised slow clock
   always_comb begin
      edge_c     = s2 ^ s3;
      rise_c     = s2 & ~s3;
      fall_c     = ~s2 & s3;
      interval_c = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
      dev_c      = (interval_c >= RATIO_V) ? interval_c - RATIO_V : RATIO_V - interval_c;
      good_c     = (dev_c <= TOL_V);
      timeout_c  = (cnt == TIMEOUT_V) && !edge_c && (state != IDLE);
      if (edge_c)
         cnt_n = '0;
      else if (cnt == CNT_MAX)
         cnt_n = cnt;
      else
         cnt_n = cnt + CNT_W'(1);
   end

   // Lock FSM next-state and status; clear is applied first so a same-cycle fault wins
   always_comb begin
      state_n    = state;
      good_run_n = good_run;
      locked_n   = locked;
      fault_n    = clear_in ? 1'b0 : fault_sticky;
      err_n      = clear_in ? 8'd0 : error_count;
      last_n     = last_half_period;
      measure_c  = 1'b0;
      case (state)
         IDLE: begin
            if (edge_c) begin
               state_n    = TRACK;
               good_run_n = '0;
            end
         end
         TRACK: begin
            if (edge_c) begin
               measure_c = 1'b1;
               if (!good_c) begin
                  good_run_n = '0;
               end else if (good_run + RUN_W'(1) == LOCK_V) begin
                  good_run_n = '0;
                  state_n    = LOCKED;
                  locked_n   = 1'b1;
               end else begin
                  good_run_n = good_run + RUN_W'(1);
               end
            end else if (timeout_c) begin
               state_n    = IDLE;
               good_run_n = '0;
            end
         end
         LOCKED: begin
            if ((edge_c && !good_c) || timeout_c) begin
               state_n    = edge_c ? TRACK : IDLE;
               good_run_n = '0;
               locked_n   = 1'b0;
               fault_n    = 1'b1;
               err_n      = (err_n == ERR_MAX) ? ERR_MAX : err_n + 8'd1;
            end
            if (edge_c)
               measure_c = 1'b1;
         end
         default: begin
            state_n    = IDLE;
            good_run_n = '0;
            locked_n   = 1'b0;
         end
      endcase
      if (measure_c)
         last_n = interval_c;
   end

   always_ff @(posedge original_clock or posedge reset_in) begin
      if (reset_in) begin
         s1               <= 1'b0;
         s2               <= 1'b0;
         s3               <= 1'b0;
         state            <= IDLE;
         cnt              <= '0;
         good_run         <= '0;
         rise_pulse       <= 1'b0;
         fall_pulse       <= 1'b0;
         locked           <= 1'b0;
         fault_sticky     <= 1'b0;
         error_count      <= 8'd0;
         last_half_period <= '0;
      end else begin
         s1               <= slow_clock_in;
         s2               <= s1;
         s3               <= s2;
         state            <= state_n;
         cnt              <= cnt_n;
         good_run         <= good_run_n;
         rise_pulse       <= rise_c;
         fall_pulse       <= fall_c;
         locked           <= locked_n;
         fault_sticky     <= fault_n;
         error_count      <= err_n;
         last_half_period <= last_n;
      end
   end

`ifdef CLK_MON_MINMAX_EN
   logic [CNT_W-1:0] min_n, max_n;

   // Extremes over every measured interval; clear restarts them before a same-cycle update
   always_comb begin
      min_n = clear_in ? CNT_MAX : min_interval;
      max_n = clear_in ? '0 : max_interval;
      if (measure_c) begin
         if (interval_c < min_n)
            min_n = interval_c;
         if (interval_c > max_n)
            max_n = interval_c;
      end
   end

   always_ff @(posedge original_clock or posedge reset_in) begin
      if (reset_in) begin
         min_interval <= CNT_MAX;
         max_interval <= '0;
      end else begin
         min_interval <= min_n;
         max_interval <= max_n;
      end
   end
`else
   assign min_interval = '0;
   assign max_interval = '0;
`endif

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Directed bench for clk_ratio_monitor at RATIO=5, TOL=0, LOCK_COUNT=4, TIMEOUT=20.
// Expected min/max follow CLK_MON_MINMAX_EN when it is defined for the build.
module tb_clk_ratio_monitor;
   logic       original_clock;
   logic       reset_in;
   logic       slow_clock_in;
   logic       clear_in;
   logic       rise_pulse;
   logic       fall_pulse;
   logic       locked;
   logic       fault_sticky;
   logic [7:0] last_half_period;
   logic [7:0] error_count;
   logic [7:0] min_interval;
   logic [7:0] max_interval;

   int vectors;
   int miscompares;

`ifdef CLK_MON_MINMAX_EN
   localparam logic [7:0] MIN_RST = 8'hFF;
   localparam bit         MM_ON   = 1'b1;
`else
   localparam logic [7:0] MIN_RST = 8'h00;
   localparam bit         MM_ON   = 1'b0;
`endif

   clk_ratio_monitor #(
      .RATIO(5), .TOL(0), .LOCK_COUNT(4), .TIMEOUT(20), .CNT_W(8)
   ) dut (
      .original_clock  (original_clock),
      .reset_in        (reset_in),
      .slow_clock_in   (slow_clock_in),
      .clear_in        (clear_in),
      .rise_pulse      (rise_pulse),
      .fall_pulse      (fall_pulse),
      .locked          (locked),
      .fault_sticky    (fault_sticky),
      .last_half_period(last_half_period),
      .error_count     (error_count),
      .min_interval    (min_interval),
      .max_interval    (max_interval)
   );

   initial original_clock = 1'b0;
   always #5 original_clock = ~original_clock;

   task automatic tick();
      @(posedge original_clock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Toggle n cycles after the previous toggle; returns when the resulting pulse is visible
   task automatic edge_after(input int n);
      ticks(n - 3);
      slow_clock_in = ~slow_clock_in;
      ticks(3);
   endtask

   task automatic test_reset();
      reset_in = 1'b1; slow_clock_in = 1'b0; clear_in = 1'b0;
      ticks(2);
      vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked got %b want 0", locked); end
      vectors++; if (error_count !== 8'd0) begin miscompares++; $display("FAIL reset_err got %0d want 0", error_count); end
      vectors++; if (last_half_period !== 8'd0) begin miscompares++; $display("FAIL reset_last got %0d want 0", last_half_period); end
      vectors++; if (min_interval !== MIN_RST) begin miscompares++; $display("FAIL reset_min got %0d want %0d", min_interval, MIN_RST); end
      vectors++; if (max_interval !== 8'd0) begin miscompares++; $display("FAIL reset_max got %0d want 0", max_interval); end
      reset_in = 1'b0;
      ticks(4);
      vectors++; if ({rise_pulse, fall_pulse, fault_sticky} !== 3'b000) begin miscompares++; $display("FAIL reset_idle got %b want 000", {rise_pulse, fall_pulse, fault_sticky}); end
   endtask

   task automatic test_lock();
      edge_after(3);
      vectors++; if (rise_pulse !== 1'b1) begin miscompares++; $display("FAIL lock_first_rise got %b want 1", rise_pulse); end
      vectors++; if (last_half_period !== 8'd0) begin miscompares++; $display("FAIL lock_first_nomeas got %0d want 0", last_half_period); end
      for (int k = 2; k <= 5; k++) begin
         edge_after(5);
         vectors++; if (locked !== 1'(k == 5)) begin miscompares++; $display("FAIL lock_edge%0d locked got %b want %b", k, locked, 1'(k == 5)); end
         vectors++; if (fall_pulse !== 1'(k % 2 == 0)) begin miscompares++; $display("FAIL lock_edge%0d fall got %b", k, fall_pulse); end
         vectors++; if (last_half_period !== 8'd5) begin miscompares++; $display("FAIL lock_edge%0d last got %0d want 5", k, last_half_period); end
      end
      vectors++; if (fault_sticky !== 1'b0) begin miscompares++; $display("FAIL lock_fault got %b want 0", fault_sticky); end
      vectors++; if (min_interval !== (MM_ON ? 8'd5 : 8'd0)) begin miscompares++; $display("FAIL lock_min got %0d", min_interval); end
      vectors++; if (max_interval !== (MM_ON ? 8'd5 : 8'd0)) begin miscompares++; $display("FAIL lock_max got %0d", max_interval); end
   endtask

   task automatic test_bad_interval();
      tick();
      vectors++; if (rise_pulse !== 1'b0) begin miscompares++; $display("FAIL pulse_width got %b want 0", rise_pulse); end
      edge_after(6);
      vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL bad_locked got %b want 0", locked); end
      vectors++; if (fault_sticky !== 1'b1) begin miscompares++; $display("FAIL bad_fault got %b want 1", fault_sticky); end
      vectors++; if (error_count !== 8'd1) begin miscompares++; $display("FAIL bad_err got %0d want 1", error_count); end
      vectors++; if (last_half_period !== 8'd7) begin miscompares++; $display("FAIL bad_last got %0d want 7", last_half_period); end
      vectors++; if (max_interval !== (MM_ON ? 8'd7 : 8'd0)) begin miscompares++; $display("FAIL bad_max got %0d", max_interval); end
      for (int i = 0; i < 4; i++) begin
         edge_after(5);
         vectors++; if (locked !== 1'(i == 3)) begin miscompares++; $display("FAIL bad_relock%0d got %b", i, locked); end
      end
   endtask

   task automatic test_stuck();
      ticks(20);
      vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL stuck_early got %b want 1", locked); end
      tick();
      vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL stuck_locked got %b want 0", locked); end
      vectors++; if (error_count !== 8'd2) begin miscompares++; $display("FAIL stuck_err got %0d want 2", error_count); end
      edge_after(5);
      vectors++; if (last_half_period !== 8'd5) begin miscompares++; $display("FAIL stuck_idle_nomeas got %0d want 5", last_half_period); end
      for (int i = 0; i < 4; i++) begin
         edge_after(5);
         vectors++; if (locked !== 1'(i == 3)) begin miscompares++; $display("FAIL stuck_relock%0d got %b", i, locked); end
      end
   endtask

   task automatic test_clear_collision();
      ticks(5);
      slow_clock_in = ~slow_clock_in;
      ticks(2);
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL coll_locked got %b want 0", locked); end
      vectors++; if (fault_sticky !== 1'b1) begin miscompares++; $display("FAIL coll_fault got %b want 1", fault_sticky); end
      vectors++; if (error_count !== 8'd1) begin miscompares++; $display("FAIL coll_err got %0d want 1", error_count); end
      vectors++; if (last_half_period !== 8'd8) begin miscompares++; $display("FAIL coll_last got %0d want 8", last_half_period); end
      vectors++; if (min_interval !== (MM_ON ? 8'd8 : 8'd0)) begin miscompares++; $display("FAIL coll_min got %0d", min_interval); end
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      vectors++; if ({fault_sticky, error_count} !== 9'd0) begin miscompares++; $display("FAIL clear_state got %b/%0d want 0/0", fault_sticky, error_count); end
      vectors++; if (min_interval !== MIN_RST) begin miscompares++; $display("FAIL clear_min got %0d want %0d", min_interval, MIN_RST); end
      edge_after(4);
      for (int i = 1; i < 4; i++) begin
         vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL clear_nolock%0d got %b want 0", i, locked); end
         edge_after(5);
      end
      vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL clear_relock got %b want 1", locked); end
   endtask

   task automatic test_reset_midlock();
      #2;
      reset_in = 1'b1;
      slow_clock_in = 1'b0;
      #1;
      vectors++; if ({locked, fault_sticky, rise_pulse, fall_pulse} !== 4'b0000) begin miscompares++; $display("FAIL rst_async_flags got %b want 0000", {locked, fault_sticky, rise_pulse, fall_pulse}); end
      vectors++; if (last_half_period !== 8'd0) begin miscompares++; $display("FAIL rst_async_last got %0d want 0", last_half_period); end
      vectors++; if (min_interval !== MIN_RST) begin miscompares++; $display("FAIL rst_async_min got %0d want %0d", min_interval, MIN_RST); end
      ticks(2);
      reset_in = 1'b0;
      ticks(4);
      edge_after(3);
      vectors++; if (rise_pulse !== 1'b1) begin miscompares++; $display("FAIL rst_first_rise got %b want 1", rise_pulse); end
      vectors++; if (last_half_period !== 8'd0) begin miscompares++; $display("FAIL rst_first_nomeas got %0d want 0", last_half_period); end
      for (int i = 0; i < 4; i++) begin
         edge_after(5);
         vectors++; if (locked !== 1'(i == 3)) begin miscompares++; $display("FAIL rst_relock%0d got %b", i, locked); end
      end
   endtask

   task automatic test_minmax();
      reset_in = 1'b1;
      slow_clock_in = 1'b0;
      ticks(2);
      reset_in = 1'b0;
      ticks(3);
      edge_after(3);
      edge_after(5);
      edge_after(4);
      edge_after(6);
      vectors++; if (last_half_period !== 8'd6) begin miscompares++; $display("FAIL mm_last got %0d want 6", last_half_period); end
      vectors++; if (min_interval !== (MM_ON ? 8'd4 : 8'd0)) begin miscompares++; $display("FAIL mm_min got %0d", min_interval); end
      vectors++; if (max_interval !== (MM_ON ? 8'd6 : 8'd0)) begin miscompares++; $display("FAIL mm_max got %0d", max_interval); end
      vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL mm_locked got %b want 0", locked); end
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      vectors++; if (min_interval !== MIN_RST) begin miscompares++; $display("FAIL mm_clear_min got %0d want %0d", min_interval, MIN_RST); end
      vectors++; if (max_interval !== 8'd0) begin miscompares++; $display("FAIL mm_clear_max got %0d want 0", max_interval); end
   endtask

   task automatic test_saturation();
      edge_after(4);
      for (int i = 0; i < 3; i++) edge_after(5);
      vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL sat_start got %b want 1", locked); end
      for (int i = 1; i <= 260; i++) begin
         edge_after(7);
         if (i == 254 || i == 255 || i == 256) begin
            vectors++;
            if (error_count !== ((i == 254) ? 8'd254 : 8'd255)) begin
               miscompares++; $display("FAIL sat_loss%0d got %0d", i, error_count);
            end
         end
         for (int j = 0; j < 4; j++) edge_after(5);
      end
      vectors++; if (error_count !== 8'd255) begin miscompares++; $display("FAIL sat_final got %0d want 255", error_count); end
      vectors++; if ({locked, fault_sticky} !== 2'b11) begin miscompares++; $display("FAIL sat_flags got %b want 11", {locked, fault_sticky}); end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_lock();
      test_bad_interval();
      test_stuck();
      test_clear_collision();
      test_reset_midlock();
      test_minmax();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
